// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared encodings for the run controller. These cover host
//               command ops, controller states and halt causes.
// Revision    : 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

    // Host command opcodes carried on cmd_op
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_RUN     = 3'd1,
        OP_STEP    = 3'd2,
        OP_HALT    = 3'd3,
        OP_SET_BP  = 3'd4,
        OP_CLR_BP  = 3'd5,
        OP_CLR_CNT = 3'd6,
        OP_RSVD    = 3'd7
    } cmd_op_e;

    // Controller states; HALTED is the reset state
    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_e;

    // Reason for the most recent entry into HALTED
    typedef enum logic [1:0] {
        CAUSE_HOST = 2'd0,
        CAUSE_STEP = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_SELF = 2'd3
    } halt_cause_e;

    localparam int RETIRE_W = 32;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_cnt
// Description : Retired-instruction counter. It increments once per commit,
//               wraps naturally, and a clear in the same cycle as an
//               increment wins.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl_cnt
    import run_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rstd,
    input  logic                inc,
    input  logic                clr,
    output logic [RETIRE_W-1:0] count
);

    logic [RETIRE_W-1:0] r_count;

    // Count commits; clear has priority over increment
    always_ff @(posedge clk) begin
        if (rstd) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run controller for the single-cycle processor. It decides
//               each cycle whether the instruction at pc commits, and it
//               supports host run/halt/step, a PC breakpoint and halt on a
//               self-loop.
//               Optional feature macro: RUN_CTRL_BP_EN (breakpoint logic).
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int STEP_W         = 16,
    parameter int SELF_LOOP_HALT = 1
)
(
    input  logic        clk,
    input  logic        rstd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] pc,
    input  logic [31:0] nextpc,
    output logic        commit,
    output logic        running,
    output logic [1:0]  halt_cause,
    output logic        cmd_err,
    output logic [31:0] retired
);

    localparam logic [STEP_W-1:0] c_step_one = {{(STEP_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    halt_cause_e       r_cause;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_cmd_err;

    cmd_op_e           w_op;
    logic              w_running;
    logic              w_bp_hit;
    logic              w_acc_run;
    logic              w_acc_step;
    logic              w_acc_halt;
    logic              w_clr_cnt;
    logic              w_cmd_bad;
    logic              w_self_loop;
    logic              w_step_last;
    logic [STEP_W-1:0] w_step_load;

    assign w_op        = cmd_op_e'(cmd_op);
    assign w_running   = (r_state != ST_HALTED);
    assign w_acc_run   = cmd_valid && (w_op == OP_RUN);
    assign w_acc_step  = cmd_valid && (w_op == OP_STEP);
    assign w_acc_halt  = cmd_valid && (w_op == OP_HALT);
    assign w_clr_cnt   = cmd_valid && (w_op == OP_CLR_CNT);
    // Reserved op, or a RUN/STEP that arrives while already running
    assign w_cmd_bad   = cmd_valid && ((w_op == OP_RSVD) ||
                         (w_running && ((w_op == OP_RUN) || (w_op == OP_STEP))));
    assign w_self_loop = (SELF_LOOP_HALT != 0) && (nextpc == pc);
    assign w_step_last = (r_state == ST_STEP) && (r_step_cnt == c_step_one);
    // A step count of zero still executes one instruction
    assign w_step_load = (cmd_arg[STEP_W-1:0] == '0) ? c_step_one
                                                     : cmd_arg[STEP_W-1:0];

    // Upper argument bits carry no meaning for step counts
    generate
        if (STEP_W < 32) begin : g_arg_unused
            logic w_unused_arg_hi;
            assign w_unused_arg_hi = ^cmd_arg[31:STEP_W];
        end
    endgenerate

`ifdef RUN_CTRL_BP_EN
    logic        r_bp_valid;
    logic [31:0] r_bp_addr;
    logic        r_skip_bp;

    // Skip lets a resumed run execute the instruction it stopped on
    assign w_bp_hit = r_bp_valid && (pc == r_bp_addr) && !r_skip_bp;

    // Breakpoint register, written by SET_BP and invalidated by CLR_BP
    always_ff @(posedge clk) begin
        if (rstd) begin
            r_bp_valid <= 1'b0;
            r_bp_addr  <= '0;
        end else if (cmd_valid && (w_op == OP_SET_BP)) begin
            r_bp_valid <= 1'b1;
            r_bp_addr  <= cmd_arg;
        end else if (cmd_valid && (w_op == OP_CLR_BP)) begin
            r_bp_valid <= 1'b0;
        end
    end

    // Arm the skip on an accepted RUN/STEP, drop it at the first commit
    always_ff @(posedge clk) begin
        if (rstd) begin
            r_skip_bp <= 1'b0;
        end else if (!w_running && (w_acc_run || w_acc_step)) begin
            r_skip_bp <= 1'b1;
        end else if (commit) begin
            r_skip_bp <= 1'b0;
        end
    end
`else
    assign w_bp_hit = 1'b0;
`endif

    // Run-state FSM with step counter, halt cause and error pulse
    always_ff @(posedge clk) begin
        if (rstd) begin
            r_state    <= ST_HALTED;
            r_cause    <= CAUSE_HOST;
            r_step_cnt <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_bad;
            case (r_state)
                ST_HALTED: begin
                    if (w_acc_run) begin
                        r_state <= ST_RUN;
                    end else if (w_acc_step) begin
                        r_state    <= ST_STEP;
                        r_step_cnt <= w_step_load;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (w_bp_hit) begin
                        // No commit this cycle, so the step count is kept
                        r_state <= ST_HALTED;
                        r_cause <= CAUSE_BP;
                    end else begin
                        // Not stopped by a breakpoint means this cycle commits
                        if (r_state == ST_STEP) begin
                            r_step_cnt <= r_step_cnt - c_step_one;
                        end
                        if (w_self_loop) begin
                            r_state <= ST_HALTED;
                            r_cause <= CAUSE_SELF;
                        end else if (w_step_last) begin
                            r_state <= ST_HALTED;
                            r_cause <= CAUSE_STEP;
                        end else if (w_acc_halt) begin
                            r_state <= ST_HALTED;
                            r_cause <= CAUSE_HOST;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    run_ctrl_cnt u_cnt (
        .clk   (clk),
        .rstd  (rstd),
        .inc   (commit),
        .clr   (w_clr_cnt),
        .count (retired)
    );

    assign cmd_ready  = 1'b1;
    assign commit     = w_running && !w_bp_hit;
    assign running    = w_running;
    assign halt_cause = r_cause;
    assign cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl
// Description : Directed self-checking bench for run_ctrl. A second instance
//               has the self-loop halt disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    logic        clk;
    logic        rstd;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] pc;
    logic        loop_mode;
    wire  [31:0] nextpc;

    wire         cmd_ready, commit, running, cmd_err;
    wire  [1:0]  halt_cause;
    wire  [31:0] retired;

    wire         nl_cmd_ready, nl_commit, nl_running, nl_cmd_err;
    wire  [1:0]  nl_halt_cause;
    wire  [31:0] nl_retired;

    int n_checks = 0;
    int n_errors = 0;

    assign nextpc = loop_mode ? pc : pc + 32'd1;

    run_ctrl dut (
        .clk        (clk),
        .rstd       (rstd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .pc         (pc),
        .nextpc     (nextpc),
        .commit     (commit),
        .running    (running),
        .halt_cause (halt_cause),
        .cmd_err    (cmd_err),
        .retired    (retired)
    );

    run_ctrl #(.SELF_LOOP_HALT(0)) dut_noloop (
        .clk        (clk),
        .rstd       (rstd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (nl_cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .pc         (pc),
        .nextpc     (nextpc),
        .commit     (nl_commit),
        .running    (nl_running),
        .halt_cause (nl_halt_cause),
        .cmd_err    (nl_cmd_err),
        .retired    (nl_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock: the datapath model advances pc when the cycle committed
    task automatic cycle();
        logic c;
        c = commit;
        @(posedge clk);
        #1;
        if (c) pc = nextpc;
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cycle();
    endtask

    task automatic do_reset();
        rstd = 1'b1;
        cycle();
        rstd      = 1'b0;
        pc        = 32'd0;
        loop_mode = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        rstd      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 32'd0;
        pc        = 32'd0;
        loop_mode = 1'b0;
        do_reset();

        // Reset values
        check_eq("rst_commit",  {31'd0, commit},  0);
        check_eq("rst_running", {31'd0, running}, 0);
        check_eq("rst_cause",   {30'd0, halt_cause}, 0);
        check_eq("rst_cmd_err", {31'd0, cmd_err}, 0);
        check_eq("rst_retired", retired, 0);
        check_eq("rst_ready",   {31'd0, cmd_ready}, 1);

        // RUN: commits from the next cycle, ten cycles give ten retires
        for (int i = 0; i < 4; i++) cycle();
        check_eq("idle_commit", {31'd0, commit}, 0);
        send(3'd1, 32'd0);
        check_eq("run_running", {31'd0, running}, 1);
        check_eq("run_commit",  {31'd0, commit}, 1);
        for (int i = 0; i < 10; i++) cycle();
        check_eq("run_retired10", retired, 10);
        check_eq("run_pc10", pc, 10);
        check_eq("run_cause", {30'd0, halt_cause}, 0);

        // RUN while running: one-cycle error pulse, keeps running
        send(3'd1, 32'd0);
        check_eq("rerun_err", {31'd0, cmd_err}, 1);
        check_eq("rerun_running", {31'd0, running}, 1);
        cycle();
        check_eq("rerun_err_clr", {31'd0, cmd_err}, 0);
        check_eq("rerun_retired", retired, 12);

        // Reserved op
        send(3'd7, 32'd0);
        check_eq("op7_err", {31'd0, cmd_err}, 1);
        cycle();
        check_eq("op7_err_clr", {31'd0, cmd_err}, 0);

        // Clear wins over a simultaneous commit
        send(3'd6, 32'd0);
        check_eq("clr_cnt", retired, 0);

        // Host HALT: the handshake-cycle instruction still commits
        send(3'd3, 32'd0);
        check_eq("halt_retired", retired, 1);
        check_eq("halt_pc", pc, 16);
        check_eq("halt_running", {31'd0, running}, 0);
        check_eq("halt_commit", {31'd0, commit}, 0);
        check_eq("halt_cause", {30'd0, halt_cause}, 0);
        cycle();
        check_eq("halted_hold", retired, 1);

        // STEP 3: exactly three commits
        do_reset();
        send(3'd2, 32'd3);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (commit) n++;
            cycle();
        end
        check_eq("step3_commits", n, 3);
        check_eq("step3_retired", retired, 3);
        check_eq("step3_cause", {30'd0, halt_cause}, 1);
        check_eq("step3_running", {31'd0, running}, 0);

        // STEP 0 behaves as STEP 1
        send(3'd2, 32'd0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (commit) n++;
            cycle();
        end
        check_eq("step0_commits", n, 1);
        check_eq("step0_retired", retired, 4);

        // Breakpoint at 4, run from 0
        do_reset();
        send(3'd4, 32'h0000_0004);
        check_eq("setbp_err", {31'd0, cmd_err}, 0);
        send(3'd1, 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!running) break;
            if (commit) n++;
            cycle();
        end
`ifdef RUN_CTRL_BP_EN
        check_eq("bp_commits", n, 4);
        check_eq("bp_pc", pc, 4);
        check_eq("bp_cause", {30'd0, halt_cause}, 2);
        check_eq("bp_running", {31'd0, running}, 0);
        send(3'd1, 32'd0);
        check_eq("bp_resume_commit", {31'd0, commit}, 1);
        cycle();
        check_eq("bp_resume_pc", pc, 5);
        check_eq("bp_resume_commit2", {31'd0, commit}, 1);
`else
        check_eq("nobp_commits", n, 8);
        check_eq("nobp_pc", pc, 8);
        check_eq("nobp_running", {31'd0, running}, 1);
        check_eq("nobp_cause", {30'd0, halt_cause}, 0);
`endif

        // HALT in the same cycle as a breakpoint hit at 2
        do_reset();
        send(3'd4, 32'h0000_0002);
        send(3'd1, 32'd0);
        cycle();
        cycle();
        send(3'd3, 32'd0);
`ifdef RUN_CTRL_BP_EN
        check_eq("halt_bp_cause", {30'd0, halt_cause}, 2);
        check_eq("halt_bp_pc", pc, 2);
`else
        check_eq("halt_bp_cause", {30'd0, halt_cause}, 0);
        check_eq("halt_bp_pc", pc, 3);
`endif

        // Self-loop at 0x10
        do_reset();
        pc        = 32'h10;
        loop_mode = 1'b1;
        send(3'd1, 32'd0);
        check_eq("loop_commit", {31'd0, commit}, 1);
        cycle();
        check_eq("loop_running", {31'd0, running}, 0);
        check_eq("loop_cause", {30'd0, halt_cause}, 3);
        check_eq("loop_retired", retired, 1);
        check_eq("loop_commit_off", {31'd0, commit}, 0);
        check_eq("noloop_running", {31'd0, nl_running}, 1);
        cycle();
        check_eq("noloop_retired", nl_retired, 2);
        check_eq("noloop_commit", {31'd0, nl_commit}, 1);
        loop_mode = 1'b0;

        // Counter wrap from a preset near all-ones
        do_reset();
        force dut.u_cnt.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.u_cnt.r_count;
        cycle();
        send(3'd1, 32'd0);
        cycle();
        check_eq("wrap_ffff", retired, 32'hFFFF_FFFF);
        cycle();
        check_eq("wrap_zero", retired, 0);
        cycle();
        check_eq("wrap_one", retired, 1);

        // Reset mid-STEP
        do_reset();
        send(3'd4, 32'h0000_0020);
        send(3'd2, 32'd10);
        cycle();
        cycle();
        check_eq("midstep_running", {31'd0, running}, 1);
        rstd = 1'b1;
        cycle();
        check_eq("midrst_commit", {31'd0, commit}, 0);
        check_eq("midrst_running", {31'd0, running}, 0);
        check_eq("midrst_step_cnt", {16'd0, dut.r_step_cnt}, 0);
        check_eq("midrst_cause", {30'd0, halt_cause}, 0);
`ifdef RUN_CTRL_BP_EN
        check_eq("midrst_bp_valid", {31'd0, dut.r_bp_valid}, 0);
`endif
        rstd = 1'b0;
        cycle();
        check_eq("midrst_idle", {31'd0, commit}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
